// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the boot loader: FSM state encoding and memory sizes.
// CHECK/ERROR states exist only when BOOT_LOADER_CHECKSUM_EN is defined.
package boot_loader_pkg;

   localparam int IMEM_WORDS_DEF = 512;
   localparam int DMEM_WORDS_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_D = 3'd1,
      ST_LOAD_I = 3'd2,
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHECK  = 3'd3,
      ST_ERROR  = 3'd6,
`endif
      ST_SETTLE = 3'd4,
      ST_RUN    = 3'd5
   } state_t;

   // Word index to byte address.
   function automatic logic [31:0] word_addr(input logic [29:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/boot_loader_csum.sv
// 32-bit wrap-around accumulator of loaded words; used only under BOOT_LOADER_CHECKSUM_EN.
module loader_csum (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        clr,
   input  logic        add_en,
   input  logic [31:0] data,
   output logic [31:0] sum
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)     sum <= '0;
      else if (clr)    sum <= '0;
      else if (add_en) sum <= sum + data;
   end

endmodule

// File: rtl/boot_loader.sv
// Streams DMEM then IMEM images into memory, then enables the cpu.
// Optional checksum trailer word enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [31:0] addr_ext,
   output logic [31:0] wdata_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] addr_ext_2,
   output logic [31:0] wdata_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
   localparam int IDX_W     = (MAX_WORDS > 2) ? $clog2(MAX_WORDS) : 1;
   localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DMEM_WORDS - 1);
   localparam logic [IDX_W-1:0] I_LAST = IDX_W'(IMEM_WORDS - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;

   assign ren_ext   = 1'b0;
   assign ren_ext_2 = 1'b0;

`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [31:0] csum;

   loader_csum u_csum (
      .clk    (clk),
      .arst_n (arst_n),
      .clr    ((state == ST_IDLE) && start),
      .add_en (s_valid && ((state == ST_LOAD_D) || (state == ST_LOAD_I))),
      .data   (s_data),
      .sum    (csum)
   );

   assign s_ready = (state == ST_LOAD_D) || (state == ST_LOAD_I) || (state == ST_CHECK);
   assign busy    = (state == ST_LOAD_D) || (state == ST_LOAD_I) || (state == ST_CHECK) ||
                    (state == ST_SETTLE);
`else
   assign s_ready = (state == ST_LOAD_D) || (state == ST_LOAD_I);
   assign busy    = (state == ST_LOAD_D) || (state == ST_LOAD_I) || (state == ST_SETTLE);
   assign error   = 1'b0;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         addr_ext    <= '0;
         wdata_ext   <= '0;
         wen_ext     <= 1'b0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
         wen_ext_2   <= 1'b0;
         cpu_enable  <= 1'b0;
         done        <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         error       <= 1'b0;
`endif
      end else begin
         // Write strobes and buses are single-cycle; idle cycles drive zero.
         addr_ext    <= '0;
         wdata_ext   <= '0;
         wen_ext     <= 1'b0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
         wen_ext_2   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_LOAD_D;
                  idx   <= '0;
               end
            end
            ST_LOAD_D: begin
               if (s_valid) begin
                  wen_ext_2   <= 1'b1;
                  addr_ext_2  <= word_addr(30'(idx));
                  wdata_ext_2 <= s_data;
                  if (idx == D_LAST) begin
                     idx   <= '0;
                     state <= ST_LOAD_I;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_LOAD_I: begin
               if (s_valid) begin
                  wen_ext   <= 1'b1;
                  addr_ext  <= word_addr(30'(idx));
                  wdata_ext <= s_data;
                  if (idx == I_LAST) begin
                     idx   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                     state <= ST_CHECK;
`else
                     state <= ST_SETTLE;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (s_valid) begin
                  if (s_data == csum) begin
                     state <= ST_SETTLE;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            ST_ERROR: ;
`endif
            // One spare cycle lets the last memory write land before the cpu starts.
            ST_SETTLE: begin
               state      <= ST_RUN;
               cpu_enable <= 1'b1;
               done       <= 1'b1;
            end
            ST_RUN: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: randomized word streams against a queue model of
// expected memory writes; checksum scenarios compiled in with BOOT_LOADER_CHECKSUM_EN.
module tb_boot_loader;

   localparam int IW = 4;
   localparam int DW = 4;
   localparam int NW = IW + DW;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic        cpu_enable, busy, done, error;

   boot_loader #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .addr_ext    (addr_ext),
      .wdata_ext   (wdata_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .addr_ext_2  (addr_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_imem;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int          n_checks = 0;
   int          n_fail = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   bit          mon_ok;
   logic        acc_prev = 1'b0;
   logic [31:0] words[NW];
   logic [31:0] csum;
   logic [31:0] dmem_exp[DW], imem_exp[IW], dmem_obs[DW], imem_obs[IW];

   // Every cycle: strobe rules, and each accepted load word must show up as the next write.
   always @(negedge clk) begin
      if (!arst_n) begin
         acc_prev = 1'b0;
      end else begin
         n_checks++;
         if (ren_ext !== 1'b0 || ren_ext_2 !== 1'b0 || (wen_ext === 1'b1 && wen_ext_2 === 1'b1)) begin
            n_fail++;
            $display("FAIL strobes: ren=%b ren2=%b wen=%b wen2=%b, required ren=0 ren2=0 and wen/wen2 exclusive",
                     ren_ext, ren_ext_2, wen_ext, wen_ext_2);
         end
         n_checks++;
         if (acc_prev && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_imem)
               mon_ok = wen_ext === 1'b1 && wen_ext_2 === 1'b0 && addr_ext === mon_e.addr && wdata_ext === mon_e.data;
            else
               mon_ok = wen_ext_2 === 1'b1 && wen_ext === 1'b0 && addr_ext_2 === mon_e.addr && wdata_ext_2 === mon_e.data;
            if (!mon_ok) begin
               n_fail++;
               $display("FAIL write: got wen=%b a=%h d=%h wen2=%b a2=%h d2=%h, required imem=%0d addr=%h data=%h",
                        wen_ext, addr_ext, wdata_ext, wen_ext_2, addr_ext_2, wdata_ext_2,
                        mon_e.is_imem, mon_e.addr, mon_e.data);
            end
         end else if ({wen_ext, wen_ext_2} !== 2'b00 || addr_ext !== '0 || wdata_ext !== '0 ||
                      addr_ext_2 !== '0 || wdata_ext_2 !== '0) begin
            n_fail++;
            $display("FAIL idle_bus: wen=%b a=%h d=%h wen2=%b a2=%h d2=%h, required all 0",
                     wen_ext, addr_ext, wdata_ext, wen_ext_2, addr_ext_2, wdata_ext_2);
         end
         if (wen_ext === 1'b1 && addr_ext < 32'(IW * 4))      imem_obs[addr_ext[3:2]] = wdata_ext;
         if (wen_ext_2 === 1'b1 && addr_ext_2 < 32'(DW * 4))  dmem_obs[addr_ext_2[3:2]] = wdata_ext_2;
         acc_prev = s_valid && s_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      start = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      exp_q.delete();
      for (int i = 0; i < DW; i++) dmem_obs[i] = '0;
      for (int i = 0; i < IW; i++) imem_obs[i] = '0;
      tick();
      tick();
      arst_n = 1'b1;
   endtask

   // Model: first DW words go to dmem[i], the rest to imem[i-DW]; checksum is their sum.
   task automatic prepare(input bit rnd);
      wr_t w;
      csum = '0;
      exp_q.delete();
      for (int i = 0; i < NW; i++) begin
         words[i] = rnd ? $urandom : 32'(i + 1);
         csum += words[i];
         w.is_imem = (i >= DW);
         w.addr    = 32'(((i >= DW) ? i - DW : i) * 4);
         w.data    = words[i];
         exp_q.push_back(w);
         if (i < DW) dmem_exp[i] = words[i];
         else        imem_exp[i - DW] = words[i];
      end
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      s_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         s_data = $urandom;
         tick();
      end
      s_data = '0;
   endtask

   task automatic stream(input int first, input int last, input int gap_after, input int gap_len,
                         input bit rnd_gaps);
      for (int i = first; i <= last; i++) begin
         if (rnd_gaps && $urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
         s_valid = 1'b1;
         s_data  = words[i];
         tick();
         s_valid = 1'b0;
         s_data  = '0;
         if (i == gap_after) idle_cycles(gap_len);
      end
   endtask

   // Completes a load (checksum trailer if built in) and checks RUN entry timing and memory image.
   task automatic finish_load();
`ifdef BOOT_LOADER_CHECKSUM_EN
      s_valid = 1'b1;
      s_data  = csum;
      tick();
      s_valid = 1'b0;
      s_data  = '0;
`endif
      @(negedge clk);
      n_checks++;
      if ({busy, cpu_enable, done} !== 3'b100) begin
         n_fail++;
         $display("FAIL settle: busy,cpu_en,done=%b, required 100", {busy, cpu_enable, done});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({busy, cpu_enable, done, error, s_ready} !== 5'b01100) begin
         n_fail++;
         $display("FAIL run: busy,cpu_en,done,err,rdy=%b, required 01100",
                  {busy, cpu_enable, done, error, s_ready});
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_writes: %0d left, required 0", exp_q.size());
      end
      for (int i = 0; i < DW; i++) begin
         n_checks++;
         if (dmem_obs[i] !== dmem_exp[i]) begin
            n_fail++;
            $display("FAIL dmem[%0d]: %h, required %h", i, dmem_obs[i], dmem_exp[i]);
         end
      end
      for (int i = 0; i < IW; i++) begin
         n_checks++;
         if (imem_obs[i] !== imem_exp[i]) begin
            n_fail++;
            $display("FAIL imem[%0d]: %h, required %h", i, imem_obs[i], imem_exp[i]);
         end
      end
      tick();
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({s_ready, addr_ext, wdata_ext, wen_ext, ren_ext, addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2,
           cpu_enable, busy, done, error} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: some output nonzero (rdy=%b busy=%b done=%b cpu=%b), required all 0",
                  s_ready, busy, done, cpu_enable);
      end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      prepare(1'b0);
      start_load();
      stream(0, NW - 1, -1, 0, 1'b0);
      finish_load();
      // start in RUN must not restart anything
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({cpu_enable, done, busy, s_ready} !== 4'b1100) begin
         n_fail++;
         $display("FAIL run_start_ignored: cpu,done,busy,rdy=%b, required 1100",
                  {cpu_enable, done, busy, s_ready});
      end
      tick();
   endtask

   task automatic test_gap();
      do_reset();
      prepare(1'b0);
      start_load();
      stream(0, NW - 1, 1, 3, 1'b0);
      finish_load();
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         do_reset();
         prepare(1'b1);
         start_load();
         stream(0, NW - 1, -1, 0, 1'b1);
         finish_load();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      prepare(1'b0);
      start_load();
      stream(0, 4, -1, 0, 1'b0);
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({wen_ext, wen_ext_2, busy, s_ready, addr_ext, wdata_ext} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: wen=%b wen2=%b busy=%b rdy=%b, required 0",
                  wen_ext, wen_ext_2, busy, s_ready);
      end
      exp_q.delete();
      tick();
      arst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, s_ready, cpu_enable} !== 4'b0000) begin
         n_fail++;
         $display("FAIL post_reset_idle: busy,done,rdy,cpu=%b, required 0000",
                  {busy, done, s_ready, cpu_enable});
      end
      tick();
      prepare(1'b1);
      start_load();
      @(negedge clk);
      n_checks++;
      if ({busy, done, s_ready} !== 3'b101) begin
         n_fail++;
         $display("FAIL restart: busy,done,rdy=%b, required 101", {busy, done, s_ready});
      end
      tick();
      stream(0, NW - 1, -1, 0, 1'b1);
      finish_load();
   endtask

   task automatic test_start_ignored();
      do_reset();
      prepare(1'b1);
      start_load();
      stream(0, DW, -1, 0, 1'b0);
      start = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({busy, s_ready, done} !== 3'b110) begin
         n_fail++;
         $display("FAIL load_i_start: busy,rdy,done=%b, required 110", {busy, s_ready, done});
      end
      tick();
      stream(DW + 1, DW + 1, -1, 0, 1'b0);
      start = 1'b0;
      stream(DW + 2, NW - 1, -1, 0, 1'b0);
      finish_load();
   endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
   task automatic test_checksum_bad();
      do_reset();
      prepare(1'b0);
      start_load();
      stream(0, NW - 1, -1, 0, 1'b0);
      s_valid = 1'b1;
      s_data  = csum + 32'd1;
      tick();
      s_valid = 1'b0;
      s_data  = '0;
      start   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({error, cpu_enable, s_ready, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL csum_error: err,cpu,rdy,busy,done=%b, required 10000",
                     {error, cpu_enable, s_ready, busy, done});
         end
         tick();
      end
      start = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_random();
      test_reset_mid();
      test_start_ignored();
`ifdef BOOT_LOADER_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 512: number of instruction-memory words loaded.
REQ-002 Parameter DMEM_WORDS, default 1024: number of data-memory words loaded.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a load sequence; sampled only in IDLE.
REQ-006 s_valid  input  1  upstream word-stream valid.
REQ-007 s_data  input  32  upstream word-stream data.
REQ-008 s_ready  output  1  loader accepts a word this cycle.
REQ-009 addr_ext, wdata_ext  output  32 each  instruction-memory byte address and write data.
REQ-010 wen_ext, ren_ext  output  1 each  instruction-memory write and read strobes.
REQ-011 addr_ext_2, wdata_ext_2  output  32 each  data-memory byte address and write data.
REQ-012 wen_ext_2, ren_ext_2  output  1 each  data-memory write and read strobes.
REQ-013 cpu_enable  output  1  drives the cpu enable input.
REQ-014 busy, done, error  output  1 each  status flags.

Function
REQ-015 States SHALL be: IDLE, LOAD_D, LOAD_I, CHECK (only with the macro), SETTLE, RUN, ERROR.
REQ-016 IDLE with start=1 -> LOAD_D on the next edge; start SHALL be ignored in all other states.
REQ-017 s_ready SHALL be 1 only in LOAD_D, LOAD_I and CHECK; a word is accepted when s_valid and s_ready are both 1.
REQ-018 Each word accepted in LOAD_D SHALL appear on the next cycle as a single-cycle write: wen_ext_2=1, addr_ext_2=index<<2, wdata_ext_2=word.
REQ-019 Each word accepted in LOAD_I SHALL appear on the next cycle as a single-cycle write: wen_ext=1, addr_ext=index<<2, wdata_ext=word.
REQ-020 The index SHALL start at 0 in each load state and increment by 1 per accepted word; s_valid=0 stalls loading with no write issued.
REQ-021 The accept of word DMEM_WORDS-1 SHALL switch the state to LOAD_I; the accept of word IMEM_WORDS-1 SHALL switch it to SETTLE, or to CHECK when the macro is defined.
REQ-022 SETTLE SHALL last exactly 1 cycle and then go to RUN, so that the final memory write completes before cpu_enable rises.
REQ-023 RUN SHALL set cpu_enable=1 and done=1 and hold them until reset; there is no return to IDLE.
REQ-024 busy SHALL be 1 in LOAD_D, LOAD_I, CHECK and SETTLE, and 0 otherwise.
REQ-025 ren_ext and ren_ext_2 SHALL be held at 0; address and data outputs SHALL return to 0 in any cycle without a write.
REQ-026 At most one of wen_ext and wen_ext_2 SHALL be 1 in any cycle.

Reset
REQ-027 While arst_n=0 (asynchronous), the state SHALL be IDLE, counters and checksum 0, and every output 0.
REQ-028 Reset mid-load SHALL abort the sequence with no further writes; a new start SHALL restart the load from DMEM index 0.

Configuration
REQ-029 Macro BOOT_LOADER_CHECKSUM_EN defined: the loader SHALL accumulate a 32-bit wrap-around sum of all loaded words, then accept one extra word in CHECK.
- Equal to the sum -> SETTLE.
- Not equal -> ERROR: error=1, cpu_enable=0, s_ready=0, held until reset.
REQ-030 Macro BOOT_LOADER_CHECKSUM_EN undefined: there SHALL be no CHECK state, no accumulator and no ERROR entry, and error SHALL be tied to 0.

Structure
REQ-031 Package boot_loader_pkg SHALL hold the state enumeration typedef and the default IMEM_WORDS/DMEM_WORDS constants.
REQ-032 The checksum accumulator SHALL be a sub-module, loader_csum, instantiated only under BOOT_LOADER_CHECKSUM_EN; everything else stays flat.

Verification
REQ-033 Set IMEM_WORDS=4, DMEM_WORDS=4 and stream words 1..8 with s_valid held at 1 -> dmem addresses 0,4,8,12 receive 1..4, imem addresses 0,4,8,12 receive 5..8, and cpu_enable rises exactly 2 cycles after the last accept.
REQ-034 Same load with s_valid deasserted for 3 cycles after word 2 -> no write pulses during the gap, and the final memory contents are unchanged.
REQ-035 Drop arst_n for 1 cycle after word 5, then start again -> loading restarts at dmem address 0, and busy=1 with done=0 afterwards.
REQ-036 Assert start during LOAD_I -> no effect: the index is not reset.
REQ-037 With BOOT_LOADER_CHECKSUM_EN, stream words 1..8 followed by 0x24 -> RUN; followed by 0x25 -> ERROR with error=1 and cpu_enable=0.
REQ-038 Check every cycle of all tests -> wen_ext and wen_ext_2 are never 1 together, and ren_ext and ren_ext_2 are always 0.
